// File: rtl/rf_write_arbiter_if.sv
// Bundle of the arbiter's source handshakes, register-file write port and scoreboard queries.
interface rf_write_arbiter_if #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
);
  logic                  req0Valid;
  logic                  req0Ready;
  logic [ADDR_WIDTH-1:0] req0Addr;
  logic [DATA_WIDTH-1:0] req0Data;
  logic [2:0]            req0PPP;

  logic                  req1Valid;
  logic                  req1Ready;
  logic [ADDR_WIDTH-1:0] req1Addr;
  logic [DATA_WIDTH-1:0] req1Data;
  logic [2:0]            req1PPP;

  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic [2:0]            wrPPP;

  logic [ADDR_WIDTH-1:0] qAddr0;
  logic [ADDR_WIDTH-1:0] qAddr1;
  logic                  qBusy0;
  logic                  qBusy1;

  // Source side: writeback units, issue-stage queries, register file observer.
  modport master (
    output req0Valid, req0Addr, req0Data, req0PPP,
    input  req0Ready,
    output req1Valid, req1Addr, req1Data, req1PPP,
    input  req1Ready,
    input  wrEn, wrAddr, wrData, wrPPP,
    output qAddr0, qAddr1,
    input  qBusy0, qBusy1
  );

  modport slave (
    input  req0Valid, req0Addr, req0Data, req0PPP,
    output req0Ready,
    input  req1Valid, req1Addr, req1Data, req1PPP,
    output req1Ready,
    output wrEn, wrAddr, wrData, wrPPP,
    input  qAddr0, qAddr1,
    output qBusy0, qBusy1
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-source arbiter for the register-file write port with a pending-write scoreboard.
// Optional macro RF_WAW_COLLAPSE_EN: a same-address collision drops the older entry.
module rf_write_arbiter #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               reset,
  rf_write_arbiter_if.slave bus
);
  logic [1:0]            in_valid;
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [2:0]            in_ppp  [2];

  logic [1:0]            hv_reg;
  logic [ADDR_WIDTH-1:0] addr_reg [2];
  logic [DATA_WIDTH-1:0] data_reg [2];
  logic [2:0]            ppp_reg  [2];
  logic                  older_reg;   // index of the older entry when both are valid
  logic                  older_next;
  logic                  rr_last_reg;

  logic [1:0]            grant;
  logic [1:0]            drop;
  logic [1:0]            clear;
  logic [1:0]            load;
  logic [1:0]            keep;
  logic [1:0]            ready;
  logic                  grant_idx;
  logic                  same_addr;

  logic                  wr_en_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [2:0]            wr_ppp_reg;

  logic [ADDR_WIDTH-1:0] q_addr [2];
  logic [1:0]            q_busy;

  assign in_valid   = {bus.req1Valid, bus.req0Valid};
  assign in_addr[0] = bus.req0Addr;
  assign in_addr[1] = bus.req1Addr;
  assign in_data[0] = bus.req0Data;
  assign in_data[1] = bus.req1Data;
  assign in_ppp[0]  = bus.req0PPP;
  assign in_ppp[1]  = bus.req1PPP;
  assign q_addr[0]  = bus.qAddr0;
  assign q_addr[1]  = bus.qAddr1;

  assign bus.req0Ready = ready[0];
  assign bus.req1Ready = ready[1];
  assign bus.qBusy0    = q_busy[0];
  assign bus.qBusy1    = q_busy[1];
  assign bus.wrEn      = wr_en_reg;
  assign bus.wrAddr    = wr_addr_reg;
  assign bus.wrData    = wr_data_reg;
  assign bus.wrPPP     = wr_ppp_reg;

  assign same_addr = (addr_reg[0] == addr_reg[1]);
  assign grant_idx = grant[1];

  // Arbitration looks only at registered state, so Ready never depends on Valid.
  always_comb begin
    grant = 2'b00;
    drop  = 2'b00;
    if (hv_reg == 2'b11) begin
      if (same_addr) begin
`ifdef RF_WAW_COLLAPSE_EN
        if (addr_reg[0] != '0) begin
          drop[older_reg]   = 1'b1;
          grant[~older_reg] = 1'b1;
        end else begin
          grant[older_reg] = 1'b1;
        end
`else
        grant[older_reg] = 1'b1;
`endif
      end else begin
        grant[~rr_last_reg] = 1'b1;
      end
    end else begin
      grant = hv_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      assign clear[gi] = grant[gi] | drop[gi];
      assign ready[gi] = ~hv_reg[gi] | clear[gi];
      assign load[gi]  = in_valid[gi] & ready[gi];
      assign keep[gi]  = hv_reg[gi] & ~clear[gi];
    end
  endgenerate

  // A surviving entry is older than anything loaded beside it; simultaneous loads favour req0.
  always_comb begin
    older_next = 1'b0;
    if (keep == 2'b11)
      older_next = older_reg;
    else if (keep[1])
      older_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        hv_reg[i]   <= 1'b0;
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
        ppp_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        hv_reg[i] <= load[i] | keep[i];
        if (load[i]) begin
          addr_reg[i] <= in_addr[i];
          data_reg[i] <= in_data[i];
          ppp_reg[i]  <= in_ppp[i];
        end
      end
    end
  end

  // R0 writes are consumed but suppressed; the payload outputs hold their last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      older_reg   <= 1'b0;
      rr_last_reg <= 1'b1;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_ppp_reg  <= '0;
    end else begin
      older_reg <= older_next;
      wr_en_reg <= 1'b0;
      if (|grant) begin
        rr_last_reg <= grant_idx;
        if (addr_reg[grant_idx] != '0) begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= addr_reg[grant_idx];
          wr_data_reg <= data_reg[grant_idx];
          wr_ppp_reg  <= ppp_reg[grant_idx];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_query
      assign q_busy[gi] = (q_addr[gi] != '0) &
                          ((hv_reg[0] & (addr_reg[0] == q_addr[gi])) |
                           (hv_reg[1] & (addr_reg[1] == q_addr[gi])) |
                           (wr_en_reg & (wr_addr_reg == q_addr[gi])));
    end
  endgenerate
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a transaction-level model predicts ready/busy and the write order.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DEPTH(32), .DATA_WIDTH(64)) bus ();
  rf_write_arbiter #(.DEPTH(32), .DATA_WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          v;
    logic [4:0]  a;
    logic [63:0] d;
    logic [2:0]  p;
    int unsigned seq;
  } ent_t;
  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
    logic [2:0]  p;
  } wr_t;

  ent_t        m_ent [2];
  int          m_last;
  bit          m_wr_pend;
  logic [4:0]  m_wr_addr;
  int unsigned cyc;
  wr_t         exp_q [$];

  bit          held  [2];
  bit          cur_v [2];
  logic [4:0]  cur_a [2];
  logic [63:0] cur_d [2];
  logic [2:0]  cur_p [2];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ent[i].v = 0;
      held[i]    = 0;
      cur_v[i]   = 0;
    end
    m_last    = 1;
    m_wr_pend = 0;
  endfunction

  // Pick the winner from the rules: lone entry, oldest on same address, else alternate.
  function automatic void model_grant(output int g, output int dr);
    int old_i;
    g  = -1;
    dr = -1;
    if (m_ent[0].v && m_ent[1].v) begin
      old_i = (m_ent[0].seq < m_ent[1].seq) ? 0 : 1;
      if (m_ent[0].a == m_ent[1].a) begin
`ifdef RF_WAW_COLLAPSE_EN
        if (m_ent[0].a != 0) begin
          dr = old_i;
          g  = 1 - old_i;
        end else g = old_i;
`else
        g = old_i;
`endif
      end else g = 1 - m_last;
    end else if (m_ent[0].v) g = 0;
    else if (m_ent[1].v) g = 1;
  endfunction

  function automatic bit model_busy(input logic [4:0] q);
    if (q == 0) return 0;
    return (m_ent[0].v && m_ent[0].a == q) || (m_ent[1].v && m_ent[1].a == q) ||
           (m_wr_pend && m_wr_addr == q);
  endfunction

  task automatic do_cycle(input bit v0, input logic [4:0] a0, input logic [63:0] d0, input logic [2:0] p0,
                          input bit v1, input logic [4:0] a1, input logic [63:0] d1, input logic [2:0] p1);
    int   g, dr;
    bit   rdy [2];
    logic [4:0] q [2];
    wr_t  w;
    @(negedge clk);
    if (!held[0]) begin cur_v[0] = v0; cur_a[0] = a0; cur_d[0] = d0; cur_p[0] = p0; end
    if (!held[1]) begin cur_v[1] = v1; cur_a[1] = a1; cur_d[1] = d1; cur_p[1] = p1; end
    q[0] = 5'($urandom_range(0, 9));
    q[1] = 5'($urandom_range(0, 9));
    bus.req0Valid = cur_v[0]; bus.req0Addr = cur_a[0]; bus.req0Data = cur_d[0]; bus.req0PPP = cur_p[0];
    bus.req1Valid = cur_v[1]; bus.req1Addr = cur_a[1]; bus.req1Data = cur_d[1]; bus.req1PPP = cur_p[1];
    bus.qAddr0 = q[0];
    bus.qAddr1 = q[1];
    #1;
    model_grant(g, dr);
    for (int i = 0; i < 2; i++) rdy[i] = !m_ent[i].v || g == i || dr == i;
    check("req0Ready", bus.req0Ready, rdy[0]);
    check("req1Ready", bus.req1Ready, rdy[1]);
    check("qBusy0", bus.qBusy0, model_busy(q[0]));
    check("qBusy1", bus.qBusy1, model_busy(q[1]));
    if (g >= 0) begin
      m_last    = g;
      m_wr_pend = (m_ent[g].a != 0);
      m_wr_addr = m_ent[g].a;
      if (m_wr_pend) begin
        w.a = m_ent[g].a; w.d = m_ent[g].d; w.p = m_ent[g].p;
        exp_q.push_back(w);
      end
      m_ent[g].v = 0;
    end else m_wr_pend = 0;
    if (dr >= 0) m_ent[dr].v = 0;
    for (int i = 0; i < 2; i++) begin
      if (cur_v[i] && rdy[i]) begin
        m_ent[i].v   = 1;
        m_ent[i].a   = cur_a[i];
        m_ent[i].d   = cur_d[i];
        m_ent[i].p   = cur_p[i];
        m_ent[i].seq = cyc * 2 + i;
      end
      held[i] = cur_v[i] && !rdy[i];
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    idle(2);
    do_cycle(1, 5'd20, 64'hDEAD_BEEF, 3'd2, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    bus.req0Valid = 0;
    bus.req1Valid = 0;
    bus.qAddr0    = 5'd20;
    bus.qAddr1    = 5'd20;
    reset = 1'b0;
    #1;
    check("rst_req0Ready", bus.req0Ready, 1);
    check("rst_req1Ready", bus.req1Ready, 1);
    check("rst_wrEn", bus.wrEn, 0);
    check("rst_qBusy0_held", bus.qBusy0, 0);
    model_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    idle(3);
  endtask

  // Monitor: every committed write must match the oldest predicted write.
  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.wrEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("wrAddr", bus.wrAddr, w.a);
          check("wrData", bus.wrData, w.d);
          check("wrPPP", bus.wrPPP, w.p);
        end
      end
    end
  end

  initial begin : stimulus
    cyc = 0;
    model_reset();
    bus.req0Valid = 0; bus.req0Addr = 0; bus.req0Data = 0; bus.req0PPP = 0;
    bus.req1Valid = 0; bus.req1Addr = 0; bus.req1Data = 0; bus.req1PPP = 0;
    bus.qAddr0 = 5'd5;
    bus.qAddr1 = 5'd7;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_wrEn", bus.wrEn, 0);
    check("reset_wrAddr", bus.wrAddr, 0);
    check("reset_wrData", bus.wrData, 0);
    check("reset_wrPPP", bus.wrPPP, 0);
    check("reset_req0Ready", bus.req0Ready, 1);
    check("reset_req1Ready", bus.req1Ready, 1);
    check("reset_qBusy0", bus.qBusy0, 0);
    check("reset_qBusy1", bus.qBusy1, 0);
    #19 reset = 1'b1;

    // Single source back-to-back on one address.
    repeat (4) do_cycle(1, 5'd5, 64'hA5A5_0000_0000_0001, 3'b101, 0, 0, 0, 0);
    idle(2);

    // Round-robin between two distinct addresses; first grant goes to req0.
    model_reset();
    mid_reset();
    repeat (8) do_cycle(1, 5'd3, {$urandom, $urandom}, 3'($urandom), 1, 5'd7, {$urandom, $urandom}, 3'($urandom));
    idle(3);

    // WAW on address 9 with req1 older: single req1 write first so req0 wins the next tie-break.
    do_cycle(0, 0, 0, 0, 1, 5'd15, 64'd15, 3'd1);
    idle(2);
    do_cycle(1, 5'd4, 64'd4, 3'd3, 1, 5'd9, 64'd1, 3'd4);
    do_cycle(1, 5'd9, 64'd2, 3'd5, 0, 0, 0, 0);
    idle(4);

    // R0 write is consumed but never reaches the register file.
    do_cycle(1, 5'd0, {64{1'b1}}, 3'd7, 0, 0, 0, 0);
    idle(3);

    // req0 on 12 competing with a stream of req1 traffic.
    do_cycle(1, 5'd12, 64'h12, 3'd2, 1, 5'd1, 64'h100, 3'd0);
    repeat (4) do_cycle(0, 0, 0, 0, 1, 5'($urandom_range(1, 8)), {$urandom, $urandom}, 3'($urandom));
    idle(3);

    repeat (600)
      do_cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 9)), {$urandom, $urandom}, 3'($urandom),
               $urandom_range(0, 9) < 7, 5'($urandom_range(0, 9)), {$urandom, $urandom}, 3'($urandom));
    idle(4);

    mid_reset();
    repeat (100)
      do_cycle($urandom_range(0, 1), 5'($urandom_range(0, 4)), {$urandom, $urandom}, 3'($urandom),
               $urandom_range(0, 1), 5'($urandom_range(0, 4)), {$urandom, $urandom}, 3'($urandom));
    idle(4);

    check("drain_pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
